// File: rtl/cpu68k_bus_pkg.sv
// Shared encodings for the 68k-style peripheral bus master and its helpers.
package cpu68k_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      STROBE  = 2'd2,
      RELEASE = 2'd3
   } bus_state_e;

   localparam logic RW_READ        = 1'b1;
   localparam logic RW_WRITE       = 1'b0;
   localparam logic DTACK_ASSERTED = 1'b0;

   localparam int unsigned SETUP_W = 4;
   localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/cpu68k_wait_counter.sv
// Clear/enable cycle counter; hit flags the cycle that completes 'limit' enabled cycles.
module cpu68k_wait_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] limit,
   output logic             hit
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

   // count holds the number of cycles already completed, so the last one is limit-1.
   assign hit = en && (count == limit - WIDTH'(1));

endmodule

// File: rtl/cpu68k_bus_master.sv
// Initiator for the 68k-style strobe/dtack peripheral bus.
// Optional stuck-bus timeout enabled by defining CPU68K_BUS_TIMEOUT_EN.
module cpu68k_bus_master
   import cpu68k_bus_pkg::*;
#(
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned SETUP_CYCLES   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        rdata,
   output logic              bus_cs,
   output logic              bus_ds,
   output logic              bus_rw,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        uio_out,
   output logic              uio_oe,
   input  logic [7:0]        uio_in,
   input  logic              dtack
);

   if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255)
   begin : g_bad_params
      $error("cpu68k_bus_master: SETUP_CYCLES or TIMEOUT_CYCLES out of range");
   end

   bus_state_e state;
   logic       err_flag;

   logic setup_clear, setup_en, setup_hit;
   logic ack, release_ok, strobe_to, release_to;

   assign ack        = (state == STROBE) && (dtack == DTACK_ASSERTED);
   assign release_ok = (state == RELEASE) && (dtack != DTACK_ASSERTED);

   assign setup_en    = (state == SETUP);
   assign setup_clear = rst || !setup_en;

   cpu68k_wait_counter #(
      .WIDTH (SETUP_W)
   ) u_setup_cnt (
      .clk   (clk),
      .clear (setup_clear),
      .en    (setup_en),
      .limit (SETUP_W'(SETUP_CYCLES)),
      .hit   (setup_hit)
   );

`ifdef CPU68K_BUS_TIMEOUT_EN
   logic wait_clear, wait_en, wait_hit;

   assign wait_en    = (state == STROBE) || (state == RELEASE);
   // Restart on every entry to STROBE (held clear outside) and to RELEASE (leaving STROBE).
   assign wait_clear = rst || !wait_en || ack || strobe_to;

   cpu68k_wait_counter #(
      .WIDTH (TIMER_W)
   ) u_wait_cnt (
      .clk   (clk),
      .clear (wait_clear),
      .en    (wait_en),
      .limit (TIMER_W'(TIMEOUT_CYCLES)),
      .hit   (wait_hit)
   );

   assign strobe_to  = (state == STROBE) && wait_hit && !ack;
   assign release_to = (state == RELEASE) && wait_hit && !release_ok;
`else
   assign strobe_to  = 1'b0;
   assign release_to = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bus_cs   <= 1'b0;
         bus_ds   <= 1'b0;
         bus_rw   <= RW_READ;
         uio_oe   <= 1'b0;
         bus_addr <= '0;
         uio_out  <= '0;
         rdata    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_flag <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  state    <= SETUP;
                  busy     <= 1'b1;
                  bus_cs   <= 1'b1;
                  bus_rw   <= req_rw;
                  bus_addr <= req_addr;
                  if (req_rw == RW_WRITE) begin
                     uio_out <= req_wdata;
                     uio_oe  <= 1'b1;
                  end
               end
            end
            SETUP: begin
               if (setup_hit) begin
                  state  <= STROBE;
                  bus_ds <= 1'b1;
               end
            end
            STROBE: begin
               if (ack || strobe_to) begin
                  // bus_rw still holds the latched direction on this edge.
                  if (ack && bus_rw == RW_READ) begin
                     rdata <= uio_in;
                  end
                  err_flag <= strobe_to;
                  state    <= RELEASE;
                  bus_cs   <= 1'b0;
                  bus_ds   <= 1'b0;
                  uio_oe   <= 1'b0;
                  bus_rw   <= RW_READ;
               end
            end
            RELEASE: begin
               if (release_ok || release_to) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  err   <= release_ok ? err_flag : 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu68k_bus_master.sv
// Directed bench for cpu68k_bus_master with a completion scoreboard.
module tb_cpu68k_bus_master;

   localparam int unsigned SETUP_N = 2;
`ifdef CPU68K_BUS_TIMEOUT_EN
   localparam int unsigned TO_N = 10;
`else
   localparam int unsigned TO_N = 255;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic       req_rw = 1'b0;
   logic [7:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       busy, done, err;
   logic [7:0] rdata;
   logic       bus_cs, bus_ds, bus_rw;
   logic [7:0] bus_addr, uio_out;
   logic       uio_oe;
   logic [7:0] uio_in = '0;
   logic       dtack = 1'b1;

   typedef struct packed {
      logic       rd;
      logic [7:0] data;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   pushed = 0;
   int   done_count = 0;

   cpu68k_bus_master #(
      .ADDR_W         (8),
      .SETUP_CYCLES   (SETUP_N),
      .TIMEOUT_CYCLES (TO_N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .bus_cs    (bus_cs),
      .bus_ds    (bus_ds),
      .bus_rw    (bus_rw),
      .bus_addr  (bus_addr),
      .uio_out   (uio_out),
      .uio_oe    (uio_oe),
      .uio_in    (uio_in),
      .dtack     (dtack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic rd, input logic [7:0] data, input logic e);
      exp_q.push_back('{rd: rd, data: data, err: e});
      pushed++;
   endtask

   // Scoreboard side: every done pulse retires the oldest expected transfer.
   always begin
      @(posedge clk);
      #1;
      if (done) begin
         done_count++;
         tests++;
         assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_done: observed done=1 expected no done");
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("sb_err", err, mon_e.err);
            if (mon_e.rd) check("sb_rdata", rdata, mon_e.data);
            check("sb_busy_at_done", busy, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int started, ndone, cnt;
      logic prev_cs, prev_done, saw_done;

      // Reset state
      tick();
      tick();
      check("rst_cs", bus_cs, 0);
      check("rst_ds", bus_ds, 0);
      check("rst_rw", bus_rw, 1);
      check("rst_oe", uio_oe, 0);
      check("rst_addr", bus_addr, 0);
      check("rst_wdata", uio_out, 0);
      check("rst_rdata", rdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done_err", {done, err}, 0);
      rst = 1'b0;
      tick();

      // Write, acknowledged on the second STROBE cycle
      push_exp(1'b0, 8'h00, 1'b0);
      req = 1'b1; req_rw = 1'b0; req_addr = 8'h12; req_wdata = 8'hA5;
      tick();
      req = 1'b0; req_addr = 8'hFF; req_wdata = 8'h00;
      check("wr_setup_busy", busy, 1);
      check("wr_setup_cs", bus_cs, 1);
      check("wr_setup_ds", bus_ds, 0);
      check("wr_setup_rw", bus_rw, 0);
      check("wr_setup_addr", bus_addr, 8'h12);
      check("wr_setup_oe", uio_oe, 1);
      check("wr_setup_data", uio_out, 8'hA5);
      tick();
      check("wr_setup2_ds", bus_ds, 0);
      tick();
      check("wr_strobe1_ds", bus_ds, 1);
      check("wr_strobe1_data", uio_out, 8'hA5);
      check("wr_strobe1_addr", bus_addr, 8'h12);
      tick();
      check("wr_strobe2_ds", bus_ds, 1);
      check("wr_strobe2_oe", uio_oe, 1);
      dtack = 1'b0;
      tick();
      check("wr_rel_bus", {bus_cs, bus_ds, uio_oe, bus_rw}, 4'b0001);
      check("wr_rel_busy", busy, 1);
      check("wr_rel_done", done, 0);
      tick();
      check("wr_rel_wait_done", done, 0);
      dtack = 1'b1;
      tick();
      check("wr_done", done, 1);
      tick();
      check("wr_done_one_cycle", done, 0);

      // Read, acknowledged on the first STROBE cycle
      push_exp(1'b1, 8'h3C, 1'b0);
      req = 1'b1; req_rw = 1'b1; req_addr = 8'h34;
      tick();
      req = 1'b0;
      check("rd_setup_cs_rw_oe", {bus_cs, bus_rw, uio_oe}, 3'b110);
      tick();
      tick();
      dtack = 1'b0; uio_in = 8'h3C;
      check("rd_strobe_ds_oe", {bus_ds, uio_oe}, 2'b10);
      tick();
      check("rd_rel_rdata", rdata, 8'h3C);
      check("rd_rel_oe", uio_oe, 0);
      dtack = 1'b1; uio_in = 8'h00;
      tick();
      check("rd_done", done, 1);
      check("rd_done_rdata", rdata, 8'h3C);
      tick();

      // req while busy is dropped
      push_exp(1'b0, 8'h00, 1'b0);
      req = 1'b1; req_rw = 1'b0; req_addr = 8'h56; req_wdata = 8'h11;
      tick();
      req = 1'b0;
      tick();
      req = 1'b1; req_rw = 1'b1; req_addr = 8'h99;
      tick();
      req = 1'b0;
      check("busy_addr_kept", bus_addr, 8'h56);
      check("busy_rw_kept", bus_rw, 0);
      check("busy_data_kept", uio_out, 8'h11);
      dtack = 1'b0;
      tick();
      dtack = 1'b1;
      tick();
      check("busy_done", done, 1);
      repeat (3) tick();
      check("busy_not_queued", busy, 0);

      // Back-to-back reads with req held high; responder acks whenever ds is up
      started = 0; ndone = 0; prev_cs = 1'b0; prev_done = 1'b0;
      req = 1'b1; req_rw = 1'b1;
      for (int c = 0; c < 80 && ndone < 4; c++) begin
         req_addr = 8'h40 + 8'(started);
         tick();
         if (prev_done && ndone < 4) check("b2b_restart_after_one_idle", bus_cs, 1);
         if (bus_cs && !prev_cs) begin
            started++;
            push_exp(1'b1, 8'hC0 + 8'(started), 1'b0);
            if (started == 4) req = 1'b0;
         end
         if (done) begin
            ndone++;
            check("b2b_cs_low_at_done", bus_cs, 0);
         end
         dtack = !(bus_cs && bus_ds);
         uio_in = 8'hC0 + 8'(started);
         prev_cs = bus_cs;
         prev_done = done;
      end
      req = 1'b0; dtack = 1'b1;
      check("b2b_done_count", ndone, 4);
      check("b2b_started", started, 4);
      tick();

`ifdef CPU68K_BUS_TIMEOUT_EN
      // Stuck STROBE: ds held exactly TO_N cycles, err set, rdata untouched
      push_exp(1'b1, 8'hC4, 1'b1);
      req = 1'b1; req_rw = 1'b1; req_addr = 8'h77; uio_in = 8'hEE;
      tick();
      req = 1'b0;
      tick();
      tick();
      cnt = 0;
      for (int c = 0; c < 30 && bus_ds; c++) begin
         cnt++;
         tick();
      end
      check("to_strobe_cycles", cnt, 10);
      check("to_rel_cs", bus_cs, 0);
      tick();
      check("to_done", done, 1);
      check("to_err", err, 1);
      check("to_rdata_kept", rdata, 8'hC4);
      tick();

      // Stuck RELEASE: dtack never returns high
      push_exp(1'b1, 8'h5A, 1'b1);
      req = 1'b1; req_rw = 1'b1; req_addr = 8'h78; uio_in = 8'h5A; dtack = 1'b0;
      tick();
      req = 1'b0;
      tick();
      tick();
      tick();
      cnt = 0;
      for (int c = 0; c < 30 && busy; c++) begin
         cnt++;
         tick();
      end
      check("to_release_cycles", cnt, 10);
      check("to_rel_done", done, 1);
      check("to_rel_err", err, 1);
      dtack = 1'b1;
      tick();
`else
      // Without the timeout the master waits indefinitely for dtack
      push_exp(1'b1, 8'h69, 1'b0);
      req = 1'b1; req_rw = 1'b1; req_addr = 8'h77;
      tick();
      req = 1'b0;
      tick();
      tick();
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         saw_done |= done;
      end
      check("hang_busy", busy, 1);
      check("hang_ds", bus_ds, 1);
      check("hang_no_done", saw_done, 0);
      uio_in = 8'h69; dtack = 1'b0;
      tick();
      check("hang_rel_ds", bus_ds, 0);
      dtack = 1'b1;
      tick();
      check("hang_done", done, 1);
      check("hang_err", err, 0);
      tick();
`endif

      // Reset in the middle of a write STROBE
      req = 1'b1; req_rw = 1'b0; req_addr = 8'h21; req_wdata = 8'h5C; dtack = 1'b1;
      tick();
      req = 1'b0;
      tick();
      tick();
      check("rst_mid_pre_ds", bus_ds, 1);
      rst = 1'b1;
      tick();
      check("rst_mid_bus", {bus_cs, bus_ds, uio_oe, bus_rw}, 4'b0001);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_rdata", rdata, 0);
      rst = 1'b0; dtack = 1'b0;
      saw_done = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         saw_done |= done;
      end
      check("rst_mid_no_done", saw_done, 0);
      dtack = 1'b1;
      repeat (2) tick();

      check("sb_empty", exp_q.size(), 0);
      check("done_total", done_count, pushed);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
